tdm_decoder: RTL and testbench
==============================

Name: tdm_decoder

Overview:
Receive-side counterpart of tdm_encoder. It consumes the serial_out/sync_pulse pair produced by tdm_encoder and recovers the three parallel channel words. It provides frame alignment, lock indication and error flagging. It sits directly downstream of tdm_encoder; in loopback the encoder outputs connect straight to the decoder inputs.

Parameters:
WIDTH, 8, bits per channel word
FRAME_BITS, 3*WIDTH (derived localparam, not overridable), bits per frame

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
serial_in  input  1  serial TDM bit stream (from tdm_encoder serial_out)
sync_in  input  1  frame sync (from tdm_encoder sync_pulse)
channel1  output  WIDTH  last complete channel-1 word
channel2  output  WIDTH  last complete channel-2 word
channel3  output  WIDTH  last complete channel-3 word
frame_valid  output  1  one-cycle strobe: channel1..3 just updated
locked  output  1  frame alignment established
frame_error  output  1  one-cycle strobe: sync missing or misplaced

Behaviour:
- Line format (fixed, shared with encoder):
  - One bit per clk.
  - Frame = channel1, channel2, channel3; each word MSB first.
  - sync_in=1 exactly during bit index 0 (channel1 MSB) of every frame.
- Reset (rst=1 at an edge): channel1..3=0, frame_valid=0, locked=0, frame_error=0, bit index=0, shift register=0, state=HUNT. Applies mid-frame too: the partial frame is discarded.
- States: HUNT, ACQUIRE, LOCKED. Bit index idx counts 0..FRAME_BITS-1.
- HUNT:
  - serial_in is ignored while sync_in=0.
  - On sync_in=1: shift in bit as idx 0, set idx=1, go to ACQUIRE.
- ACQUIRE / LOCKED, every cycle: shift serial_in into LSB of FRAME_BITS-bit shift register, then idx++.
- Misplaced sync: sync_in=1 at idx!=0.
  - Pulse frame_error; drop the partial frame.
  - Treat the current bit as idx 0 (idx becomes 1).
  - Go to ACQUIRE; locked=0.
- Missing sync: sync_in=0 at idx==0 in LOCKED.
  - Pulse frame_error; go to HUNT; locked=0.
  - The bit is ignored.
- Last bit (idx==FRAME_BITS-1, no sync error on that cycle):
  - On the same edge: channel1 = bits [0..WIDTH-1] of frame, channel2 = next WIDTH, channel3 = last WIDTH.
  - frame_valid=1 for exactly the following cycle; idx wraps to 0.
  - ACQUIRE goes to LOCKED; locked=1 from that cycle.
- Latency: outputs are visible 1 cycle after the edge that samples the last frame bit.
- channel1..3 hold their value between frame_valid strobes and after errors. They are never partially updated.
- frame_valid and frame_error are never both 1. A sync error on the last-bit cycle suppresses frame_valid.
- Back-to-back frames: in LOCKED with sync at every idx 0, frame_valid pulses every FRAME_BITS cycles with no gap.
- frame_error never fires in HUNT.

Decomposition:
- Shared package tdm_pkg:
  - WIDTH default, NUM_CHANNELS=3, FRAME_BITS.
  - State encoding constants (HUNT/ACQUIRE/LOCKED).
  - Also used by tdm_encoder so the line format is defined once.
- One natural sub-module, tdm_frame_counter: idx counter with wrap, sync-aligned restart and idx==0 / idx==last flags.
- Shift register, state machine and output latches stay in tdm_decoder.

Test Plan:
- Loopback with tdm_encoder, channel1=8'hAA, channel2=8'hCC, channel3=8'hF0 -> locked rises after first frame. frame_valid pulses every 24 clks with channel1..3 = AA/CC/F0. frame_error stays 0.
- Reset: hold rst 3 cycles mid-frame -> all outputs 0 next cycle, state HUNT. After release, first frame_valid only after a full sync-aligned frame.
- Sync suppressed for one frame while LOCKED -> frame_error pulses 1 cycle at the expected idx 0; locked=0; outputs hold old values. Relock and frame_valid return after the next full frame.
- Extra sync injected at idx 10 -> frame_error pulse, no frame_valid for the interrupted frame. Next frame_valid 24 cycles after the injected sync, with data aligned to it.
- Data change mid-stream, encoder inputs to 8'h01/8'h80/8'h7E -> decoder outputs switch atomically on one frame_valid. No mixed old/new word appears.
- Stream with no sync ever (random serial_in) -> locked=0, frame_valid=0, frame_error=0 throughout; channel1..3 remain 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Line format shared by tdm_encoder and tdm_decoder: three MSB-first words per frame,
// sync asserted on the first bit of each frame.
package tdm_pkg;

    localparam int WIDTH        = 8;
    localparam int NUM_CHANNELS = 3;
    localparam int FRAME_BITS   = NUM_CHANNELS * WIDTH;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_frame_counter.sv
// Bit-position counter for one TDM frame: wraps at FRAME_BITS-1, restarts at 1 when
// the current bit is taken as a new frame start, and can be frozen.
module tdm_frame_counter #(
    parameter int FRAME_BITS = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          restart,
    input  logic                          hold,
    output logic [$clog2(FRAME_BITS)-1:0] idx,
    output logic                          is_first,
    output logic                          is_last
);

    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst)
            idx <= '0;
        else if (restart)
            idx <= IDX_W'(1);
        else if (hold)
            idx <= idx;
        else if (idx == LAST)
            idx <= '0;
        else
            idx <= idx + IDX_W'(1);
    end

    assign is_first = (idx == '0);
    assign is_last  = (idx == LAST);

endmodule

// File: rtl/tdm_decoder.sv
// TDM receiver: aligns to sync, deserialises a frame and publishes all three
// channel words together once the final bit of a clean frame arrives.
module tdm_decoder #(
    parameter int WIDTH = tdm_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             sync_in,
    output logic [WIDTH-1:0] channel1,
    output logic [WIDTH-1:0] channel2,
    output logic [WIDTH-1:0] channel3,
    output logic             frame_valid,
    output logic             locked,
    output logic             frame_error
);

    import tdm_pkg::*;

    localparam int FB    = 3 * WIDTH;
    localparam int IDX_W = $clog2(FB);

    tdm_state_e       state, next_state;
    logic [IDX_W-1:0] idx;
    logic             is_first, is_last;
    logic             cnt_restart, cnt_hold, frame_done, sync_err;
    logic [FB-2:0]    sreg;
    logic [FB-1:0]    frame;

    tdm_frame_counter #(.FRAME_BITS(FB)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .restart  (cnt_restart),
        .hold     (cnt_hold),
        .idx      (idx),
        .is_first (is_first),
        .is_last  (is_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= HUNT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        cnt_restart = 1'b0;
        cnt_hold    = 1'b0;
        frame_done  = 1'b0;
        sync_err    = 1'b0;
        case (state)
            HUNT: begin
                if (sync_in) begin
                    cnt_restart = 1'b1;
                    next_state  = ACQUIRE;
                end else begin
                    cnt_hold = 1'b1;
                end
            end
            ACQUIRE, LOCKED: begin
                if (sync_in && !is_first) begin
                    // Misplaced sync wins: realign on this bit.
                    sync_err    = 1'b1;
                    cnt_restart = 1'b1;
                    next_state  = ACQUIRE;
                end else if (!sync_in && is_first && state == LOCKED) begin
                    sync_err   = 1'b1;
                    cnt_hold   = 1'b1;
                    next_state = HUNT;
                end else if (is_last) begin
                    frame_done = 1'b1;
                    next_state = LOCKED;
                end
            end
            default: next_state = HUNT;
        endcase
    end

    // Only FB-1 bits are stored; the final bit is taken straight from the line.
    always_ff @(posedge clk) begin
        if (rst)
            sreg <= '0;
        else if (cnt_restart)
            sreg <= {{(FB-2){1'b0}}, serial_in};
        else if (state != HUNT && !cnt_hold)
            sreg <= {sreg[FB-3:0], serial_in};
    end

    assign frame = {sreg, serial_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            channel1    <= '0;
            channel2    <= '0;
            channel3    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            frame_error <= sync_err;
            if (frame_done) begin
                channel1 <= frame[FB-1 -: WIDTH];
                channel2 <= frame[FB-1-WIDTH -: WIDTH];
                channel3 <= frame[WIDTH-1:0];
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_decoder.sv
// Directed bench for tdm_decoder; the line is driven from a bit-level encoder model.
module tb_tdm_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       sync_in = 1'b0;
    logic [7:0] channel1, channel2, channel3;
    logic       frame_valid, locked, frame_error;

    int checks = 0, failures = 0;
    int exp_fv = 0, exp_err = 0;
    int fv_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, lock_cnt = 0, nz_cnt = 0;
    logic prev_fv = 1'b0;

    tdm_decoder #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .sync_in     (sync_in),
        .channel1    (channel1),
        .channel2    (channel2),
        .channel3    (channel3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_error) err_cnt++;
        if (frame_valid && frame_error) both_cnt++;
        if (frame_valid && prev_fv) long_cnt++;
        if (locked) lock_cnt++;
        if ({channel1, channel2, channel3} != 24'h0) nz_cnt++;
        prev_fv = frame_valid;
    end

    task automatic drive_bit(input logic s, input logic d);
        @(negedge clk);
        rst       = 1'b0;
        sync_in   = s;
        serial_in = d;
    endtask

    task automatic drive_bits(input logic [23:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive_bit(i == 0, f[23-i]);
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({channel1, channel2, channel3} !== 24'h0) begin
            failures++; $display("FAIL reset_channels got=%h exp=000000", {channel1, channel2, channel3});
        end
        checks++;
        if ({frame_valid, locked, frame_error} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {frame_valid, locked, frame_error});
        end
    endtask

    task automatic test_loopback;
        logic [23:0] f;
        f = {8'hAA, 8'hCC, 8'hF0};
        drive_bits(f, 0, 22);
        settle;
        checks++;
        if ({frame_valid, locked} !== 2'b00) begin
            failures++; $display("FAIL loop_prelock got=%b exp=00", {frame_valid, locked});
        end
        drive_bits(f, 23, 23);
        settle;
        exp_fv++;
        checks++;
        if ({frame_valid, locked, frame_error} !== 3'b110) begin
            failures++; $display("FAIL loop_lock got=%b exp=110", {frame_valid, locked, frame_error});
        end
        checks++;
        if ({channel1, channel2, channel3} !== f) begin
            failures++; $display("FAIL loop_data got=%h exp=%h", {channel1, channel2, channel3}, f);
        end
        for (int n = 0; n < 3; n++) begin
            drive_bits(f, 0, 23);
            settle;
            exp_fv++;
            checks++;
            if ({frame_valid, locked, channel1, channel2, channel3} !== {2'b11, f}) begin
                failures++; $display("FAIL loop_b2b%0d got=%b_%h exp=11_%h", n,
                                     {frame_valid, locked}, {channel1, channel2, channel3}, f);
            end
        end
    endtask

    task automatic test_missing_sync;
        logic [23:0] g;
        g = {8'h12, 8'h34, 8'h56};
        drive_bit(1'b0, 1'b1);
        settle;
        exp_err++;
        checks++;
        if ({frame_error, locked, frame_valid} !== 3'b100) begin
            failures++; $display("FAIL miss_err got=%b exp=100", {frame_error, locked, frame_valid});
        end
        for (int i = 1; i < 24; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)));
        settle;
        checks++;
        if ({locked, channel1, channel2, channel3} !== {1'b0, 24'hAACCF0}) begin
            failures++; $display("FAIL miss_hold got=%b_%h exp=0_aaccf0", locked, {channel1, channel2, channel3});
        end
        drive_bits(g, 0, 23);
        settle;
        exp_fv++;
        checks++;
        if ({frame_valid, locked, channel1, channel2, channel3} !== {2'b11, g}) begin
            failures++; $display("FAIL miss_relock got=%b_%h exp=11_%h",
                                 {frame_valid, locked}, {channel1, channel2, channel3}, g);
        end
    endtask

    task automatic test_extra_sync;
        logic [23:0] x, y;
        x = {8'h11, 8'h22, 8'h33};
        y = {8'h5A, 8'hA5, 8'h3C};
        drive_bits(x, 0, 9);
        drive_bits(y, 0, 0);
        settle;
        exp_err++;
        checks++;
        if ({frame_error, locked, frame_valid} !== 3'b100) begin
            failures++; $display("FAIL xsync_err got=%b exp=100", {frame_error, locked, frame_valid});
        end
        drive_bits(y, 1, 22);
        settle;
        checks++;
        if ({frame_valid, channel1, channel2, channel3} !== {1'b0, 24'h123456}) begin
            failures++; $display("FAIL xsync_nofv got=%b_%h exp=0_123456", frame_valid, {channel1, channel2, channel3});
        end
        drive_bits(y, 23, 23);
        settle;
        exp_fv++;
        checks++;
        if ({frame_valid, locked, channel1, channel2, channel3} !== {2'b11, y}) begin
            failures++; $display("FAIL xsync_realign got=%b_%h exp=11_%h",
                                 {frame_valid, locked}, {channel1, channel2, channel3}, y);
        end
    endtask

    task automatic test_data_change;
        logic [23:0] o, n;
        o = {8'hAA, 8'hCC, 8'hF0};
        n = {8'h01, 8'h80, 8'h7E};
        drive_bits(o, 0, 23);
        settle;
        exp_fv++;
        checks++;
        if ({frame_valid, channel1, channel2, channel3} !== {1'b1, o}) begin
            failures++; $display("FAIL chg_old got=%b_%h exp=1_%h", frame_valid, {channel1, channel2, channel3}, o);
        end
        drive_bits(n, 0, 22);
        settle;
        checks++;
        if ({channel1, channel2, channel3} !== o) begin
            failures++; $display("FAIL chg_partial got=%h exp=%h", {channel1, channel2, channel3}, o);
        end
        drive_bits(n, 23, 23);
        settle;
        exp_fv++;
        checks++;
        if ({frame_valid, channel1, channel2, channel3} !== {1'b1, n}) begin
            failures++; $display("FAIL chg_new got=%b_%h exp=1_%h", frame_valid, {channel1, channel2, channel3}, n);
        end
    endtask

    task automatic test_reset_midframe;
        logic [23:0] n, g;
        n = {8'h01, 8'h80, 8'h7E};
        g = {8'hC3, 8'h3C, 8'h99};
        drive_bits(n, 0, 9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b1; sync_in = 1'b0; serial_in = 1'b1;
            if (k == 0) begin
                settle;
                checks++;
                if ({channel1, channel2, channel3, frame_valid, locked, frame_error} !== 27'h0) begin
                    failures++; $display("FAIL rstmid_clear got=%h_%b exp=000000_000",
                                         {channel1, channel2, channel3}, {frame_valid, locked, frame_error});
                end
            end
        end
        for (int i = 13; i < 24; i++) drive_bit(1'b0, n[23-i]);
        settle;
        checks++;
        if ({frame_valid, locked, frame_error} !== 3'b000) begin
            failures++; $display("FAIL rstmid_hunt got=%b exp=000", {frame_valid, locked, frame_error});
        end
        drive_bits(g, 0, 22);
        settle;
        checks++;
        if ({frame_valid, locked} !== 2'b00) begin
            failures++; $display("FAIL rstmid_early got=%b exp=00", {frame_valid, locked});
        end
        drive_bits(g, 23, 23);
        settle;
        exp_fv++;
        checks++;
        if ({frame_valid, locked, channel1, channel2, channel3} !== {2'b11, g}) begin
            failures++; $display("FAIL rstmid_frame got=%b_%h exp=11_%h",
                                 {frame_valid, locked}, {channel1, channel2, channel3}, g);
        end
    endtask

    task automatic test_no_sync;
        int s_fv, s_err, s_lock, s_nz;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_fv = fv_cnt; s_err = err_cnt; s_lock = lock_cnt; s_nz = nz_cnt;
        for (int i = 0; i < 100; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)));
        settle;
        @(negedge clk);
        #1;
        checks++;
        if ((fv_cnt - s_fv) != 0 || (err_cnt - s_err) != 0) begin
            failures++; $display("FAIL nosync_pulses got=fv%0d_err%0d exp=fv0_err0", fv_cnt - s_fv, err_cnt - s_err);
        end
        checks++;
        if ((lock_cnt - s_lock) != 0 || (nz_cnt - s_nz) != 0) begin
            failures++; $display("FAIL nosync_state got=lock%0d_nz%0d exp=lock0_nz0", lock_cnt - s_lock, nz_cnt - s_nz);
        end
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_missing_sync;
        test_extra_sync;
        test_data_change;
        test_reset_midframe;
        test_no_sync;
        checks++;
        if (fv_cnt != exp_fv) begin
            failures++; $display("FAIL total_frame_valid got=%0d exp=%0d", fv_cnt, exp_fv);
        end
        checks++;
        if (err_cnt != exp_err) begin
            failures++; $display("FAIL total_frame_error got=%0d exp=%0d", err_cnt, exp_err);
        end
        checks++;
        if (both_cnt != 0 || long_cnt != 0) begin
            failures++; $display("FAIL strobe_shape got=both%0d_long%0d exp=both0_long0", both_cnt, long_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
